// File: rtl/key_counter_pkg.sv
// Shared types, segment table and sizing helper for key_counter_disp.
package key_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2
  } hold_state_t;

  // Active-high gfedcba patterns for hex digits 0..F; the top level inverts them.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int min_digits(input int cnt_w);
    return (cnt_w + 3) / 4;
  endfunction

endpackage

// File: rtl/key_hold_detect.sv
// Long-press detector for one active-low key: 2-FF synchronizer, hold FSM and counters.
// Repeat pulses in HELD are built only when AUTO_REPEAT_EN is defined.
//   state | meaning
//   IDLE  | key released, hold counter 0
//   ARM   | key pressed, hold counter running toward HOLD_CYC
//   HELD  | press reported; repeat pulses every REPEAT_CYC when built
module key_hold_detect
  import key_counter_pkg::*;
#(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 12_500_000
) (
  input  logic FPGA_CLK,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(HOLD_CYC - 1);

  if (HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("key_hold_detect: HOLD_CYC and REPEAT_CYC must be >= 1");
  end

  logic [1:0]        sync;
  logic              pressed;
  hold_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              rep_fire;

  always_ff @(posedge FPGA_CLK or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], key_n};
  end

  assign pressed   = ~sync[1];
  assign hold_done = pressed && (state != HELD) && (hold_cnt == HOLD_TC);

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_cnt;

  // Down-counter reloaded on the first press and on every repeat.
  always_ff @(posedge FPGA_CLK or posedge rst) begin
    if (rst)                      rep_cnt <= '0;
    else if (hold_done || rep_fire) rep_cnt <= REP_TC;
    else if (state == HELD)       rep_cnt <= rep_cnt - REP_W'(1);
  end

  assign rep_fire = pressed && (state == HELD) && (rep_cnt == '0);
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge FPGA_CLK or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      press    <= 1'b0;
    end else begin
      press <= hold_done | rep_fire;
      if (!pressed) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else if (hold_done) begin
        state    <= HELD;
        hold_cnt <= '0;
      end else if (state != HELD) begin
        state    <= ARM;
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_counter_disp.sv
// Long-press up/down/clear counter with a multiplexed hex seven-segment display.
// Define AUTO_REPEAT_EN to build auto-repeat into the key hold detectors.
module key_counter_disp
  import key_counter_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DIGITS     = 2,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 12_500_000,
  parameter int SCAN_CYC   = 50_000,
  parameter int SAT        = 0
) (
  input  logic              FPGA_CLK,
  input  logic              RESET_BUT,
  input  logic              KEY_UP,
  input  logic              KEY_DN,
  input  logic              KEY_CLR,
  output logic [CNT_W-1:0]  count,
  output logic              step,
  output logic              limit,
  output logic [DIGITS-1:0] DIG,
  output logic [7:0]        SEG
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_CYC - 1);
  localparam logic [1:0] DIG_TC = 2'(DIGITS - 1);

  if (CNT_W < 4 || CNT_W > 16 || DIGITS < min_digits(CNT_W) || DIGITS > 4 ||
      SCAN_CYC < 1) begin : g_bad_cfg
    $error("key_counter_disp: illegal CNT_W/DIGITS/SCAN_CYC combination");
  end

  logic up_p, dn_p, clr_p;

  key_hold_detect #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_up (
    .FPGA_CLK(FPGA_CLK), .rst(RESET_BUT), .key_n(KEY_UP), .press(up_p)
  );
  key_hold_detect #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_dn (
    .FPGA_CLK(FPGA_CLK), .rst(RESET_BUT), .key_n(KEY_DN), .press(dn_p)
  );
  key_hold_detect #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_clr (
    .FPGA_CLK(FPGA_CLK), .rst(RESET_BUT), .key_n(KEY_CLR), .press(clr_p)
  );

  logic             at_lim;
  logic [CNT_W-1:0] cnt_next;

  assign at_lim   = up_p ? (count == CNT_MAX) : (count == '0);
  assign cnt_next = up_p ? count + CNT_W'(1) : count - CNT_W'(1);

  // Clear wins; simultaneous up and down cancel out.
  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      count <= '0;
      step  <= 1'b0;
      limit <= 1'b0;
    end else begin
      step  <= 1'b0;
      limit <= 1'b0;
      if (clr_p) begin
        count <= '0;
        step  <= 1'b1;
      end else if (up_p ^ dn_p) begin
        limit <= at_lim;
        if (!(at_lim && SAT != 0)) begin
          count <= cnt_next;
          step  <= 1'b1;
        end
      end
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_idx;
  logic [15:0]       cnt_ext;
  logic [3:0]        nibble;

  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == SCAN_TC) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == DIG_TC) ? 2'd0 : dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign cnt_ext = 16'(count);
  assign nibble  = cnt_ext[{dig_idx, 2'b00} +: 4];

  always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
    if (RESET_BUT) begin
      DIG <= '1;
      SEG <= 8'hFF;
    end else begin
      DIG <= ~(DIGITS'(1) << dig_idx);
      SEG <= {1'b1, ~HEX_SEG[nibble]};
    end
  end

endmodule

// File: tb/tb_key_counter_disp.sv
// Bench for key_counter_disp: SAT=0 and SAT=1 instances against a run-length reference model.
module tb_key_counter_disp;

  localparam int CNT_W = 8, DIGITS = 2, HOLD_CYC = 4, REPEAT_CYC = 3, SCAN_CYC = 2;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, key_up = 1'b1, key_dn = 1'b1, key_clr = 1'b1;
  logic [7:0] count0, count1, seg0, seg1;
  logic       step0, step1, limit0, limit1;
  logic [1:0] dig0, dig1;

  always #5 clk = ~clk;

  key_counter_disp #(.CNT_W(CNT_W), .DIGITS(DIGITS), .HOLD_CYC(HOLD_CYC),
                     .REPEAT_CYC(REPEAT_CYC), .SCAN_CYC(SCAN_CYC), .SAT(0)) dut0 (
    .FPGA_CLK(clk), .RESET_BUT(rst), .KEY_UP(key_up), .KEY_DN(key_dn), .KEY_CLR(key_clr),
    .count(count0), .step(step0), .limit(limit0), .DIG(dig0), .SEG(seg0)
  );
  key_counter_disp #(.CNT_W(CNT_W), .DIGITS(DIGITS), .HOLD_CYC(HOLD_CYC),
                     .REPEAT_CYC(REPEAT_CYC), .SCAN_CYC(SCAN_CYC), .SAT(1)) dut1 (
    .FPGA_CLK(clk), .RESET_BUT(rst), .KEY_UP(key_up), .KEY_DN(key_dn), .KEY_CLR(key_clr),
    .count(count1), .step(step1), .limit(limit1), .DIG(dig1), .SEG(seg1)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low {dp,g..a} images of hex 0..F.
  localparam logic [7:0] SEG_REF [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // A key pulse reaches the counter 3 edges after its synced run length hits the threshold.
  function automatic bit fires(input int len);
    if (len == HOLD_CYC) return 1'b1;
    if (REP_EN && len > HOLD_CYC && ((len - HOLD_CYC) % REPEAT_CYC) == 0) return 1'b1;
    return 1'b0;
  endfunction

  int hl [3][3];
  int mcnt [2];
  int n_edges = 0;
  int stc [2], lmc [2];

  always @(posedge clk) begin
    bit         pr [3];
    bit         pk [3];
    int         idx, nxt;
    logic [7:0] eseg [2];
    logic [1:0] edig;
    logic       est [2], elm [2];
    #1;
    if (rst) begin
      for (int k = 0; k < 3; k++) for (int a = 0; a < 3; a++) hl[k][a] = 0;
      n_edges = 0;
      edig = 2'b11;
      for (int d = 0; d < 2; d++) begin
        mcnt[d] = 0; est[d] = 1'b0; elm[d] = 1'b0; eseg[d] = 8'hFF;
      end
    end else begin
      pr[0] = !key_up; pr[1] = !key_dn; pr[2] = !key_clr;
      for (int k = 0; k < 3; k++) begin
        pk[k] = fires(hl[k][2]);
        hl[k][2] = hl[k][1];
        hl[k][1] = hl[k][0];
        hl[k][0] = pr[k] ? hl[k][0] + 1 : 0;
      end
      n_edges++;
      idx  = ((n_edges - 1) / SCAN_CYC) % DIGITS;
      edig = ~(2'b01 << idx);
      for (int d = 0; d < 2; d++) begin
        eseg[d] = SEG_REF[(mcnt[d] >> (4 * idx)) & 15];
        est[d] = 1'b0; elm[d] = 1'b0;
        if (pk[2]) begin
          mcnt[d] = 0; est[d] = 1'b1;
        end else if (pk[0] != pk[1]) begin
          nxt = pk[0] ? mcnt[d] + 1 : mcnt[d] - 1;
          if (nxt < 0 || nxt > 255) begin
            elm[d] = 1'b1;
            if (d == 0) begin mcnt[d] = nxt & 255; est[d] = 1'b1; end
          end else begin
            mcnt[d] = nxt; est[d] = 1'b1;
          end
        end
      end
    end
    chk("dut0.count", count0, mcnt[0]);  chk("dut1.count", count1, mcnt[1]);
    chk("dut0.step", step0, est[0]);     chk("dut1.step", step1, est[1]);
    chk("dut0.limit", limit0, elm[0]);   chk("dut1.limit", limit1, elm[1]);
    chk("dut0.DIG", dig0, edig);         chk("dut1.DIG", dig1, edig);
    chk("dut0.SEG", seg0, eseg[0]);      chk("dut1.SEG", seg1, eseg[1]);
    if (step0 === 1'b1) stc[0]++;
    if (step1 === 1'b1) stc[1]++;
    if (limit0 === 1'b1) lmc[0]++;
    if (limit1 === 1'b1) lmc[1]++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic clr_win();
    stc[0] = 0; stc[1] = 0; lmc[0] = 0; lmc[1] = 0;
  endtask

  task automatic press(input bit u, input bit d, input bit c, input int samples);
    key_up = !u; key_dn = !d; key_clr = !c;
    repeat (samples) cyc();
    key_up = 1'b1; key_dn = 1'b1; key_clr = 1'b1;
    repeat (8) cyc();
  endtask

  typedef struct {
    bit up, dn, clr;
    int c0, c1, s0, s1, l0, l1;
  } vec_t;

  initial begin
    vec_t       tv [8];
    logic [1:0] dg [8];
    logic [7:0] sg [8];
    int         dur [3];
    logic       kv [3];

    tv[0] = '{1, 0, 0, 8'h01, 8'h01, 1, 1, 0, 0};
    tv[1] = '{1, 0, 0, 8'h02, 8'h02, 1, 1, 0, 0};
    tv[2] = '{1, 1, 0, 8'h02, 8'h02, 0, 0, 0, 0};
    tv[3] = '{0, 1, 0, 8'h01, 8'h01, 1, 1, 0, 0};
    tv[4] = '{1, 1, 1, 8'h00, 8'h00, 1, 1, 0, 0};
    tv[5] = '{0, 1, 0, 8'hFF, 8'h00, 1, 0, 1, 1};
    tv[6] = '{1, 0, 1, 8'h00, 8'h00, 1, 1, 0, 0};
    tv[7] = '{0, 0, 1, 8'h00, 8'h00, 1, 1, 0, 0};

    // Reset values.
    repeat (3) cyc();
    chk("rst_count", count0, 8'h00);
    chk("rst_step", step0, 1'b0);
    chk("rst_limit", limit1, 1'b0);
    chk("rst_dig", dig0, 2'b11);
    chk("rst_seg", seg0, 8'hFF);
    rst = 1'b0;
    cyc();
    chk("rst_release_dig0", dig0, 2'b10);
    repeat (4) cyc();

    // UP held for 18 sampled edges: first step at edge 6, repeats every 3.
    clr_win();
    key_up = 1'b0;
    for (int e = 0; e < 26; e++) begin
      cyc();
      chk($sformatf("up_hold_step_e%0d", e), step0,
          REP_EN ? (e == 6 || e == 9 || e == 12 || e == 15 || e == 18) : (e == 6));
      if (e == 17) key_up = 1'b1;
    end
    chk("up_hold_count", count0, REP_EN ? 8'd5 : 8'd1);
    chk("up_hold_limits", lmc[0], 0);

    // Simultaneous-key table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clr_win();
      press(tv[i].up, tv[i].dn, tv[i].clr, HOLD_CYC);
      chk($sformatf("tv%0d.count0", i), count0, tv[i].c0);
      chk($sformatf("tv%0d.count1", i), count1, tv[i].c1);
      chk($sformatf("tv%0d.steps0", i), stc[0], tv[i].s0);
      chk($sformatf("tv%0d.steps1", i), stc[1], tv[i].s1);
      chk($sformatf("tv%0d.limits0", i), lmc[0], tv[i].l0);
      chk($sformatf("tv%0d.limits1", i), lmc[1], tv[i].l1);
    end

    // Climb to 0xFF, then one more UP: wrap versus saturate.
    do_reset();
    for (int i = 0; i < 255; i++) press(1, 0, 0, HOLD_CYC);
    chk("ff_count0", count0, 8'hFF);
    chk("ff_count1", count1, 8'hFF);
    clr_win();
    press(1, 0, 0, HOLD_CYC);
    chk("wrap_count0", count0, 8'h00);
    chk("wrap_step0", stc[0], 1);
    chk("wrap_limit0", lmc[0], 1);
    chk("sat_count1", count1, 8'hFF);
    chk("sat_step1", stc[1], 0);
    chk("sat_limit1", lmc[1], 1);

    // Display of 0x3A: 'A' on digit 0, '3' on digit 1, two cycles each.
    do_reset();
    for (int i = 0; i < 58; i++) press(1, 0, 0, HOLD_CYC);
    chk("disp_count", count0, 8'h3A);
    for (int i = 0; i < 8; i++) begin
      cyc();
      dg[i] = dig0;
      sg[i] = seg0;
    end
    for (int i = 0; i < 8; i++) begin
      chk("disp_dig_valid", (dg[i] == 2'b10) || (dg[i] == 2'b01), 1'b1);
      chk("disp_seg", sg[i], (dg[i] == 2'b10) ? 8'h88 : 8'hB0);
      if (i < 6) chk("disp_period", dg[i] != dg[i+2], 1'b1);
    end

    // DN released for one synced cycle at hold count 3 restarts the hold.
    do_reset();
    key_dn = 1'b0;
    for (int e = 0; e < 13; e++) begin
      cyc();
      if (e == 2) key_dn = 1'b1;
      if (e == 3) key_dn = 1'b0;
      chk($sformatf("glitch_step_e%0d", e), step0, e == 10);
    end
    key_dn = 1'b1;
    repeat (8) cyc();

    // Reset during ARM with UP still held.
    key_up = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_count", count0, 8'h00);
    chk("midrst_step", step0, 1'b0);
    chk("midrst_dig", dig0, 2'b11);
    chk("midrst_seg", seg0, 8'hFF);
    cyc(); cyc();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      cyc();
      chk($sformatf("midrst_step_e%0d", e), step0, e == 6);
    end
    key_up = 1'b1;
    repeat (8) cyc();

    // Random key activity with occasional resets; the monitor checks every cycle.
    for (int k = 0; k < 3; k++) begin dur[k] = 0; kv[k] = 1'b1; end
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (dur[k] == 0) begin
          kv[k]  = !kv[k];
          dur[k] = $urandom_range(1, 9);
        end
        dur[k]--;
      end
      key_up = kv[0]; key_dn = kv[1]; key_clr = (i % 5 == 0) ? kv[2] : 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; key_up = 1'b1; key_dn = 1'b1; key_clr = 1'b1;
    repeat (8) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
